// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit saturating-counter branch predictor with tags and targets.
// Same-cycle prediction for fetch; learns from resolved branches and keeps statistics.
module branch_predictor #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_update,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        ex_mispredict,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;
  localparam int unsigned PC_W    = 32;

  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_d    [ENTRIES];
  logic [PC_W-1:0]     target_q [ENTRIES];
  logic [PC_W-1:0]     target_d [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];
  logic [1:0]          ctr_d    [ENTRIES];

  logic [PC_W-1:0] stat_branches_q, stat_branches_d;
  logic [PC_W-1:0] stat_mispredicts_q, stat_mispredicts_d;

  logic [INDEX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_BITS-1:0]   if_tag, ex_tag;
  logic                  ex_hit;
  logic                  unused_pc_lsbs;

  assign if_idx = if_pc[INDEX_BITS+1:2];
  assign if_tag = if_pc[31:INDEX_BITS+2];
  assign ex_idx = ex_pc[INDEX_BITS+1:2];
  assign ex_tag = ex_pc[31:INDEX_BITS+2];

  // Word-aligned PCs: the two low bits carry no information.
  assign unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

  // Prediction reads pre-update state; there is deliberately no bypass.
  always_comb begin
    pred_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken  = pred_hit && ctr_q[if_idx][1];
    pred_target = pred_hit ? target_q[if_idx] : 32'd0;
  end

  // A not-taken branch never mispredicts on target.
  always_comb begin
    ex_mispredict = ex_update &&
                    ((ex_taken != ex_pred_taken) ||
                     (ex_taken && (ex_target != ex_pred_target)));
  end

  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  // Table update: train on hit, allocate-and-replace on miss.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (ex_update) begin
      if (ex_hit) begin
        if (ex_taken) begin
          ctr_d[ex_idx]    = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'd1;
          target_d[ex_idx] = ex_target;
        end else begin
          ctr_d[ex_idx] = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'd1;
        end
      end else begin
        valid_d[ex_idx]  = 1'b1;
        tag_d[ex_idx]    = ex_tag;
        target_d[ex_idx] = ex_target;
        ctr_d[ex_idx]    = ex_taken ? 2'b10 : 2'b01;
      end
    end
  end

  // Saturating statistics counters.
  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (ex_update && (stat_branches_q != 32'hFFFF_FFFF)) begin
      stat_branches_d = stat_branches_q + 32'd1;
    end
    if (ex_mispredict && (stat_mispredicts_q != 32'hFFFF_FFFF)) begin
      stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end
  end

  // Tag and target need no reset: valid gates every use of them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q            <= '0;
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= 2'b01;
      end
    end else begin
      valid_q            <= valid_d;
      tag_q              <= tag_d;
      target_q           <= target_d;
      ctr_q              <= ctr_d;
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: hand-computed expectations for prediction,
// training, aliasing, mispredict detection, statistics and reset.
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_update;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        ex_mispredict;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int checks = 0;
  int errors = 0;

  branch_predictor dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_pc            (if_pc),
    .pred_hit         (pred_hit),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .ex_update        (ex_update),
    .ex_pc            (ex_pc),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .ex_mispredict    (ex_mispredict),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; drives one resolved branch across the next posedge.
  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic ptk, input logic [31:0] ptgt, input logic exp_mis);
    ex_update      = 1'b1;
    ex_pc          = pc;
    ex_taken       = tk;
    ex_target      = tgt;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
    #1 check("mispredict", 32'(ex_mispredict), 32'(exp_mis));
    @(negedge clk);
    ex_update = 1'b0;
  endtask

  task automatic pred(input string tag, input logic [31:0] pc, input logic hit,
                      input logic tk, input logic [31:0] tgt);
    if_pc = pc;
    #1;
    check({tag, "_hit"},    32'(pred_hit),   32'(hit));
    check({tag, "_taken"},  32'(pred_taken), 32'(tk));
    check({tag, "_target"}, pred_target,     tgt);
  endtask

  task automatic stats(input string tag, input logic [31:0] br, input logic [31:0] mp);
    check({tag, "_branches"},    stat_branches,    br);
    check({tag, "_mispredicts"}, stat_mispredicts, mp);
  endtask

  initial begin
    rst_n          = 1'b0;
    if_pc          = 32'h0;
    ex_update      = 1'b0;
    ex_pc          = 32'h0;
    ex_taken       = 1'b0;
    ex_target      = 32'h0;
    ex_pred_taken  = 1'b0;
    ex_pred_target = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Empty table after reset
    pred("reset", 32'h100, 1'b0, 1'b0, 32'h0);
    pred("reset_any", 32'hDEAD_BEE0, 1'b0, 1'b0, 32'h0);
    stats("reset", 32'd0, 32'd0);

    // No update means no mispredict even with disagreeing inputs
    ex_taken = 1'b1; ex_pred_taken = 1'b0;
    #1 check("idle_mispredict", 32'(ex_mispredict), 32'd0);
    @(negedge clk);

    // Allocate taken: ctr=10
    upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1);
    pred("alloc", 32'h100, 1'b1, 1'b1, 32'h80);
    stats("alloc", 32'd1, 32'd1);

    // Three taken: 11, 11, 11
    for (int i = 0; i < 3; i++) upd(32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0);
    pred("sat_hi", 32'h100, 1'b1, 1'b1, 32'h80);

    // Not-taken to 10 (mispredicted), then to 01; NT ignores target mismatch
    upd(32'h100, 1'b0, 32'h999, 1'b1, 32'h80, 1'b1);
    pred("dec1", 32'h100, 1'b1, 1'b1, 32'h80);
    upd(32'h100, 1'b0, 32'h999, 1'b0, 32'h123, 1'b0);
    pred("dec2", 32'h100, 1'b1, 1'b0, 32'h80);
    stats("train", 32'd6, 32'd2);

    // Same-cycle read and update: prediction shows pre-update state
    if_pc          = 32'h100;
    ex_update      = 1'b1;
    ex_pc          = 32'h100;
    ex_taken       = 1'b1;
    ex_target      = 32'h80;
    ex_pred_taken  = 1'b0;
    ex_pred_target = 32'h80;
    #1;
    check("same_cycle_before", 32'(pred_taken), 32'd0);
    check("same_cycle_mis", 32'(ex_mispredict), 32'd1);
    @(negedge clk);
    ex_update = 1'b0;
    #1 check("same_cycle_after", 32'(pred_taken), 32'd1);
    @(negedge clk);

    // Back to 11, then a target change on the taken path
    upd(32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0);
    upd(32'h100, 1'b1, 32'hC0, 1'b1, 32'h80, 1'b1);
    pred("retarget", 32'h100, 1'b1, 1'b1, 32'hC0);
    stats("retarget", 32'd9, 32'd4);

    // Aliasing: 0x200 shares the index with 0x100 and evicts it
    upd(32'h100, 1'b1, 32'hC0, 1'b1, 32'hC0, 1'b0);
    upd(32'h200, 1'b0, 32'h300, 1'b0, 32'h0, 1'b0);
    pred("alias_old", 32'h100, 1'b0, 1'b0, 32'h0);
    pred("alias_new", 32'h200, 1'b1, 1'b0, 32'h300);
    pred("alias_lsbs", 32'h203, 1'b1, 1'b0, 32'h300);
    stats("alias", 32'd11, 32'd4);

    // Reset wins over a simultaneous update
    rst_n          = 1'b0;
    ex_update      = 1'b1;
    ex_pc          = 32'h200;
    ex_taken       = 1'b1;
    ex_target      = 32'h440;
    ex_pred_taken  = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    ex_update = 1'b0;
    pred("rst_upd_200", 32'h200, 1'b0, 1'b0, 32'h0);
    pred("rst_upd_100", 32'h100, 1'b0, 1'b0, 32'h0);
    stats("rst_upd", 32'd0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side consumer of resolved branch outcomes; the execute-stage branch comparator produces `ex_taken`.
- Holds a direct-mapped table of 2-bit saturating counters with tags and targets.
- Gives fetch a same-cycle taken/target prediction and learns from each resolved branch.
- Flags mispredicts and keeps branch and mispredict statistics.

Parameters:
- INDEX_BITS, 6, log2 of table entries (64); index = PC[INDEX_BITS+1:2]
- TAG_BITS, 30-INDEX_BITS, tag width; tag = PC[31:INDEX_BITS+2]

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- if_pc  input  32  fetch PC to predict
- pred_hit  output  1  valid entry with matching tag for if_pc
- pred_taken  output  1  pred_hit && counter[1]
- pred_target  output  32  stored target of hit entry; 0 when no hit
- ex_update  input  1  a conditional branch resolved this cycle
- ex_pc  input  32  PC of the resolved branch
- ex_taken  input  1  resolved outcome from the branch comparator
- ex_target  input  32  computed branch target
- ex_pred_taken  input  1  prediction carried down the pipe for this branch
- ex_pred_target  input  32  predicted target carried down the pipe
- ex_mispredict  output  1  resolved outcome differs from the prediction
- stat_branches  output  32  count of ex_update cycles
- stat_mispredicts  output  32  count of ex_mispredict cycles

Behaviour:
- Storage per entry: valid, tag[TAG_BITS], target[32], ctr[2].
  - Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Reset (rst_n=0 at a clock edge):
  - All valid bits cleared and all ctr set to 01 in that one cycle.
  - stat_branches and stat_mispredicts set to 0.
  - Reset wins over a simultaneous ex_update; that update is discarded and not counted.
- Prediction path: purely combinational from if_pc and current table state, zero latency.
  - Miss: pred_hit=0, pred_taken=0, pred_target=0.
  - After reset, all prediction outputs are 0 for any if_pc.
- Mispredict: combinational, no register.
  - ex_mispredict = ex_update && ((ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target)).
  - A not-taken branch never mispredicts on target.
- Update, on a clock edge with ex_update=1 and rst_n=1:
  - Hit (valid and tag match): ctr increments saturating at 11 if ex_taken, else decrements saturating at 00. Target is overwritten with ex_target only when ex_taken=1.
  - Miss (invalid or tag mismatch): allocate and replace. Set valid=1, tag=ex_pc tag, target=ex_target, ctr = ex_taken ? 10 : 01.
  - ex_update=0: table and counters unchanged.
- Statistics:
  - stat_branches += 1 on each ex_update.
  - stat_mispredicts += 1 when ex_mispredict=1.
  - Both saturate at 32'hFFFFFFFF and do not wrap.
- Simultaneous fetch read and update to the same index:
  - The prediction reflects pre-update state; no bypass.
  - The new state is visible from the next cycle.
- ex_pc/if_pc bits [1:0] are ignored.
- Aliasing: two PCs with the same index and different tags evict each other. There is no associativity.

Test Plan:
- Reset, then if_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0; both stats 0.
- Update ex_pc=0x100, ex_taken=1, ex_target=0x80, ex_pred_taken=0 -> ex_mispredict=1 that cycle.
  - Next cycle if_pc=0x100 gives pred_hit=1, pred_taken=1 (ctr=10), pred_target=0x80.
  - stat_branches=1, stat_mispredicts=1.
- Three further taken updates to 0x100, then two not-taken updates -> ctr goes 11 (saturated), 10, 01.
  - pred_taken ends at 0 and pred_target stays 0x80.
- Alias test, INDEX_BITS=6: taken update at 0x100, then not-taken update at 0x200 (same index, different tag).
  - if_pc=0x100 -> pred_hit=0.
  - if_pc=0x200 -> pred_hit=1, pred_taken=0.
- Same-cycle read and update of index for 0x100 from ctr=01 with ex_taken=1 -> that cycle pred_taken=0; next cycle pred_taken=1.
- Target change and mispredict on taken path:
  - Setup: entry hit, ctr=11, target 0x80. Update ex_taken=1, ex_target=0xC0, ex_pred_taken=1, ex_pred_target=0x80.
  - Result: ex_mispredict=1, target becomes 0xC0.
  - Then assert rst_n=0 together with ex_update=1 -> table invalid and stats 0 the next cycle.
